// File: rtl/pc_gen_pkg.sv
// Shared constants and next-PC source encoding for the fetch-stage PC generator.
// PC bit numbering is big-endian: bit 0 is the MSB.
package pc_gen_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned INSTR_BYTES_DEF = 4;
  localparam int unsigned RAS_DEPTH_DEF   = 4;
  localparam logic [31:0] IM_BASE_ADDR    = 32'h0000_1000;

  typedef enum logic [1:0] {
    SrcExc = 2'd0,
    SrcBr  = 2'd1,
    SrcRet = 2'd2,
    SrcSeq = 2'd3
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Clear empties the stack; a pop when empty is ignored.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [0:WIDTH-1]        push_data,
  output logic [0:WIDTH-1]        top,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned         PtrW   = $clog2(DEPTH);
  localparam logic [PtrW-1:0]     PtrOne = 1;
  localparam logic [PtrW:0]       CntOne = 1;
  localparam logic [PtrW:0]       CntMax = (PtrW + 1)'(DEPTH);

  logic [0:WIDTH-1] mem_q [DEPTH];
  logic [PtrW-1:0]  ptr_q;
  logic [PtrW-1:0]  ptr_inc;
  logic [PtrW-1:0]  ptr_dec;
  logic [PtrW:0]    count_q;

  // Pointer arithmetic wraps naturally because DEPTH is a power of 2.
  assign ptr_inc = ptr_q + PtrOne;
  assign ptr_dec = ptr_q - PtrOne;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntMax);
  assign count = count_q;
  assign top   = mem_q[ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      count_q <= '0;
    end else if (push) begin
      ptr_q          <= ptr_inc;
      mem_q[ptr_inc] <= push_data;
      if (!full) begin
        count_q <= count_q + CntOne;
      end
    end else if (pop && !empty) begin
      ptr_q   <= ptr_dec;
      count_q <= count_q - CntOne;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: exception > stall > branch > return > sequential.
// Define PC_RAS_EN to add a return-address stack that predicts return targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = PC_WIDTH_DEF,
  parameter logic [0:PC_WIDTH-1] RESET_ADDR  = PC_WIDTH'(IM_BASE_ADDR),
  parameter int unsigned         INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int unsigned         RAS_DEPTH   = RAS_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                exc_valid,
  input  logic [0:PC_WIDTH-1] exc_vector,
  input  logic                br_valid,
  input  logic [0:PC_WIDTH-1] br_target,
  input  logic                br_link,
  input  logic                ret_valid,
  input  logic [0:PC_WIDTH-1] ret_target,
  output logic [0:PC_WIDTH-1] pc,
  output logic [0:PC_WIDTH-1] pc_next_seq,
  output logic                redirect,
  output logic                ras_empty,
  output logic                ras_full
);

  localparam logic [0:PC_WIDTH-1] IncrVal   = PC_WIDTH'(INSTR_BYTES);
  localparam logic [0:PC_WIDTH-1] AlignMask = ~(PC_WIDTH'(INSTR_BYTES - 1));

  logic [0:PC_WIDTH-1] pc_q;
  logic [0:PC_WIDTH-1] pc_d;
  logic [0:PC_WIDTH-1] target;
  logic [0:PC_WIDTH-1] ret_sel;
  logic                redirect_q;
  logic                redirect_d;
  logic                load;
  pc_src_e             src;

  assign pc_next_seq = pc_q + IncrVal;

  always_comb begin
    // An exception is the only source that can move the PC during a stall.
    load = exc_valid | ~stall;

    if (exc_valid) begin
      src = SrcExc;
    end else if (br_valid) begin
      src = SrcBr;
    end else if (ret_valid) begin
      src = SrcRet;
    end else begin
      src = SrcSeq;
    end

    target = pc_next_seq;
    unique case (src)
      SrcExc:  target = exc_vector;
      SrcBr:   target = br_target;
      SrcRet:  target = ret_sel;
      SrcSeq:  target = pc_next_seq;
      default: target = pc_next_seq;
    endcase

    pc_d       = load ? (target & AlignMask) : pc_q;
    redirect_d = load ? (src != SrcSeq) : redirect_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_ADDR;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc       = pc_q;
  assign redirect = redirect_q;

`ifdef PC_RAS_EN
  logic                        adv;
  logic                        ras_push;
  logic                        ras_pop;
  logic [0:PC_WIDTH-1]         ras_top;
  logic [$clog2(RAS_DEPTH):0]  ras_count;

  // Stack ops follow the same acceptance as the PC update; a branch shadows a return.
  assign adv      = ~exc_valid & ~stall;
  assign ras_push = adv & br_valid & br_link;
  assign ras_pop  = adv & ~br_valid & ret_valid & (ras_count != '0);

  pc_ras #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (exc_valid),
    .push_data (pc_next_seq),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign ret_sel = ras_empty ? ret_target : ras_top;
`else
  logic unused_ras;

  assign unused_ras = br_link ^ (RAS_DEPTH == 0);
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ret_sel    = ret_target;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; RAS-specific expectations follow PC_RAS_EN.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        exc_valid;
  logic [0:31] exc_vector;
  logic        br_valid;
  logic [0:31] br_target;
  logic        br_link;
  logic        ret_valid;
  logic [0:31] ret_target;
  logic [0:31] pc;
  logic [0:31] pc_next_seq;
  logic        redirect;
  logic        ras_empty;
  logic        ras_full;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [0:31] exp;
  logic        exp_b;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .exc_valid   (exc_valid),
    .exc_vector  (exc_vector),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .br_link     (br_link),
    .ret_valid   (ret_valid),
    .ret_target  (ret_target),
    .pc          (pc),
    .pc_next_seq (pc_next_seq),
    .redirect    (redirect),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; exc_valid = 1'b0; exc_vector = '0;
    br_valid = 1'b0; br_target = '0; br_link = 1'b0; ret_valid = 1'b0; ret_target = '0;
    step(); step();
    rst_n = 1'b1;
    n_cmp++; if (pc !== 32'h0000_1000) begin
      n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0000_1000);
    end
    n_cmp++; if (pc_next_seq !== 32'h0000_1004) begin
      n_fail++; $display("FAIL reset_next_seq: got %h want %h", pc_next_seq, 32'h0000_1004);
    end
    n_cmp++; if (redirect !== 1'b0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got redir=%b empty=%b full=%b want 0 1 0",
                         redirect, ras_empty, ras_full);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = 32'h0000_1000 + 32'(4 * i);
      n_cmp++; if (pc !== exp || redirect !== 1'b0) begin
        n_fail++; $display("FAIL seq_%0d: got pc=%h redir=%b want %h 0", i, pc, redirect, exp);
      end
    end
  endtask

  task automatic test_stall_branch();
    br_valid = 1'b1; br_target = 32'h0000_2003; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (pc !== 32'h0000_100C || redirect !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold_%0d: got pc=%h redir=%b want 0000100c 0",
                           i, pc, redirect);
      end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h0000_2000 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL branch_aligned: got pc=%h redir=%b want 00002000 1", pc, redirect);
    end
    br_valid = 1'b0; stall = 1'b1;
    step();
    n_cmp++; if (pc !== 32'h0000_2000 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL stall_keeps_redirect: got pc=%h redir=%b want 00002000 1",
                         pc, redirect);
    end
    stall = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h0000_2004 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL seq_clears_redirect: got pc=%h redir=%b want 00002004 0",
                         pc, redirect);
    end
  endtask

  task automatic test_exception();
    br_valid = 1'b1; br_link = 1'b1; br_target = 32'h0000_3000;
    step();
`ifdef PC_RAS_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    n_cmp++; if (pc !== 32'h0000_3000 || ras_empty !== exp_b) begin
      n_fail++; $display("FAIL call_before_exc: got pc=%h empty=%b want 00003000 %b",
                         pc, ras_empty, exp_b);
    end
    exc_valid = 1'b1; exc_vector = 32'h0000_0700; stall = 1'b1; br_target = 32'h0000_4000;
    step();
    n_cmp++; if (pc !== 32'h0000_0700 || redirect !== 1'b1 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL exc_priority: got pc=%h redir=%b empty=%b want 00000700 1 1",
                         pc, redirect, ras_empty);
    end
    exc_vector = 32'h0000_0903;
    step();
    n_cmp++; if (pc !== 32'h0000_0900) begin
      n_fail++; $display("FAIL exc_aligned: got %h want %h", pc, 32'h0000_0900);
    end
    exc_valid = 1'b0; stall = 1'b0; br_valid = 1'b0; br_link = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h0000_0904 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL exc_then_seq: got pc=%h redir=%b want 00000904 0", pc, redirect);
    end
  endtask

  task automatic test_ras();
    br_valid = 1'b1; br_link = 1'b0; br_target = 32'h0000_0100;
    step();
    br_link = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      br_target = 32'((i + 1) * 256);
      step();
`ifdef PC_RAS_EN
      exp_b = (i >= 4);
`else
      exp_b = 1'b0;
`endif
      n_cmp++; if (pc !== br_target || ras_full !== exp_b) begin
        n_fail++; $display("FAIL call_%0d: got pc=%h full=%b want %h %b",
                           i, pc, ras_full, br_target, exp_b);
      end
    end
    br_valid = 1'b0; br_link = 1'b0; ret_valid = 1'b1; ret_target = 32'hDEAD_BEE0;
    for (int i = 0; i < 5; i++) begin
`ifdef PC_RAS_EN
      exp = (i < 4) ? 32'h0000_0504 - 32'(i * 256) : 32'hDEAD_BEE0;
`else
      exp = 32'hDEAD_BEE0;
`endif
      step();
      n_cmp++; if (pc !== exp || redirect !== 1'b1) begin
        n_fail++; $display("FAIL return_%0d: got pc=%h redir=%b want %h 1", i, pc, redirect, exp);
      end
    end
    ret_target = 32'h0000_1236;
    step();
    ret_valid = 1'b0;
    n_cmp++; if (pc !== 32'h0000_1234 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL return_empty_aligned: got pc=%h empty=%b want 00001234 1",
                         pc, ras_empty);
    end
  endtask

  task automatic test_wrap();
    br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    br_valid = 1'b0;
    n_cmp++; if (pc !== 32'hFFFF_FFFC || pc_next_seq !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_setup: got pc=%h next=%h want fffffffc 00000000",
                         pc, pc_next_seq);
    end
    step();
    n_cmp++; if (pc !== 32'h0000_0000 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL wrap: got pc=%h redir=%b want 00000000 0", pc, redirect);
    end
  endtask

  task automatic test_back_to_back();
    br_valid = 1'b1; br_target = 32'h0000_7000;
    step();
    br_link = 1'b1; br_target = 32'h0000_7800;
    step();
    br_link = 1'b0; br_target = 32'h0000_9000; ret_valid = 1'b1; ret_target = 32'h0000_ABC0;
    step();
`ifdef PC_RAS_EN
    exp_b = 1'b0;
    exp   = 32'h0000_7004;
`else
    exp_b = 1'b1;
    exp   = 32'h0000_ABC0;
`endif
    n_cmp++; if (pc !== 32'h0000_9000 || ras_empty !== exp_b) begin
      n_fail++; $display("FAIL br_beats_ret: got pc=%h empty=%b want 00009000 %b",
                         pc, ras_empty, exp_b);
    end
    br_valid = 1'b0;
    step();
    ret_valid = 1'b0;
    n_cmp++; if (pc !== exp || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL ret_after_tie: got pc=%h empty=%b want %h 1", pc, ras_empty, exp);
    end
  endtask

  task automatic test_async_reset();
    br_valid = 1'b1; br_link = 1'b1; br_target = 32'h0000_5000;
    step();
    br_valid = 1'b0; br_link = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 32'h0000_1000 || redirect !== 1'b0 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got pc=%h redir=%b empty=%b want 00001000 0 1",
                         pc, redirect, ras_empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (pc !== 32'h0000_1004) begin
      n_fail++; $display("FAIL after_reset_seq: got %h want %h", pc, 32'h0000_1004);
    end
  endtask

  initial begin
    test_reset();
    test_stall_branch();
    test_exception();
    test_ras();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
